// File: rtl/pc_branch_ctrl_pkg.sv
// Shared pipeline definitions: default widths, reset PC, fetch FSM encoding
// and the IF/ID bundle layout (also used by the decode stage).
package pipe_pkg;

   localparam int                    DEF_WIDTH    = 16;
   localparam logic [DEF_WIDTH-1:0]  DEF_RESET_PC = 16'h0000;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_e;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] instr;
      logic [DEF_WIDTH-1:0] pc2;
      logic                 valid;
   } if_id_t;

endpackage

// File: rtl/pc_branch_ctrl_if.sv
// Fetch/branch bundle between the ID-stage logic and pc_branch_ctrl.
// slave = the branch controller, master = the surrounding pipeline.
interface pc_branch_ctrl_if import pipe_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
);
   logic             stall_i;
   logic [WIDTH-1:0] instr_i;
   logic             is_bne_i;
   logic             is_beq_i;
   logic             bneq_flag_i;
   logic [WIDTH-1:0] imm_i;
   logic [WIDTH-1:0] pc_o;
   logic [WIDTH-1:0] if_id_instr_o;
   logic [WIDTH-1:0] if_id_pc2_o;
   logic             if_id_valid_o;
   logic             flush_o;
   logic             branch_taken_o;
   logic [WIDTH-1:0] taken_count_o;

   modport slave (
      input  stall_i, instr_i, is_bne_i, is_beq_i, bneq_flag_i, imm_i,
      output pc_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, flush_o,
             branch_taken_o, taken_count_o
   );

   modport master (
      output stall_i, instr_i, is_bne_i, is_beq_i, bneq_flag_i, imm_i,
      input  pc_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, flush_o,
             branch_taken_o, taken_count_o
   );
endinterface

// File: rtl/pc_branch_ctrl_branch_target_adder.sv
// base + (ofs << 1): offsets are counted in 2-byte instructions.
// Carry-in is zero and the carry-out is dropped, so the sum wraps silently.
module branch_target_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] base_i,
   input  logic [WIDTH-1:0] ofs_i,
   output logic [WIDTH-1:0] sum_o
);
   logic [WIDTH-1:0] ofs_shl_s;

   assign ofs_shl_s = ofs_i << 1'b1;
   assign sum_o     = base_i + ofs_shl_s;
endmodule

// File: rtl/pc_branch_ctrl.sv
// Fetch PC, IF/ID register and BEQ/BNE redirect with a one-bubble squash.
// Also keeps a saturating count of taken branches.
module pc_branch_ctrl import pipe_pkg::*; #(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = DEF_RESET_PC
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_branch_ctrl_if.slave  bus
);
   localparam logic [WIDTH-1:0] ONE_INSTR = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   if_id_t           if_id_q, if_id_d;
   logic [WIDTH-1:0] taken_count_q, taken_count_d;
   logic [WIDTH-1:0] pc_plus2_s;
   logic [WIDTH-1:0] target_s;
   logic             taken_s;

   // Sequential PC: pc + (1 << 1)
   branch_target_adder #(.WIDTH(WIDTH)) u_pc_inc (
      .base_i (pc_q),
      .ofs_i  (ONE_INSTR),
      .sum_o  (pc_plus2_s)
   );

   // Branch target: pc2 of the ID instruction + (imm << 1)
   branch_target_adder #(.WIDTH(WIDTH)) u_target (
      .base_i (if_id_q.pc2),
      .ofs_i  (bus.imm_i),
      .sum_o  (target_s)
   );

   // A bubble in ID can never redirect; a stall defers resolution
   assign taken_s = if_id_q.valid & ~bus.stall_i &
                    ((bus.is_bne_i & bus.bneq_flag_i) |
                     (bus.is_beq_i & ~bus.bneq_flag_i));

   // Fetch FSM: next state, next PC and next IF/ID contents
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if_id_d = if_id_q;
      case (state_q)
         ST_RUN: begin
            if (taken_s) begin
               pc_d    = target_s;
               if_id_d = '0;
               state_d = ST_SQUASH;
            end else if (bus.stall_i) begin
               pc_d    = pc_q;
            end else begin
               pc_d    = pc_plus2_s;
               if_id_d = '{instr: bus.instr_i, pc2: pc_plus2_s, valid: 1'b1};
            end
         end
         ST_SQUASH: begin
            if (bus.stall_i) begin
               state_d = ST_SQUASH;
            end else begin
               pc_d    = pc_plus2_s;
               if_id_d = '{instr: bus.instr_i, pc2: pc_plus2_s, valid: 1'b1};
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Taken-branch counter, saturating at all ones
   always_comb begin
      taken_count_d = taken_count_q;
      if (taken_s && (taken_count_q != {WIDTH{1'b1}})) begin
         taken_count_d = taken_count_q + ONE_INSTR;
      end else begin
         taken_count_d = taken_count_q;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         if_id_q       <= '0;
         taken_count_q <= {WIDTH{1'b0}};
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_q       <= if_id_d;
         taken_count_q <= taken_count_d;
      end
   end

   assign bus.pc_o           = pc_q;
   assign bus.if_id_instr_o  = if_id_q.instr;
   assign bus.if_id_pc2_o    = if_id_q.pc2;
   assign bus.if_id_valid_o  = if_id_q.valid;
   assign bus.flush_o        = (state_q == ST_SQUASH);
   assign bus.branch_taken_o = taken_s;
   assign bus.taken_count_o  = taken_count_q;
endmodule
